// File: rtl/pgm_tx_sched.sv
// Pacing scheduler for the packet generator read path: paces replays of the stored packet,
// tags latency probes, and keeps per-run packet/probe statistics.
//
// state | meaning
// IDLE  | no run; config regs writable, waiting for start
// REQ   | requesting a packet from the reader (tx_req while not almost-full)
// XMIT  | reader accepted, waiting for EOP (tx_done)
// GAP   | inter-packet gap countdown before the next request
// FIN   | one-cycle end-of-run, run_finish asserted
module pgm_tx_sched #(
    parameter int GAP_W   = 32,
    parameter int PROBE_W = 32,
    parameter int TOTAL_W = 64
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               cfg_wr,
    input  logic [1:0]         cfg_addr,
    input  logic [63:0]        cfg_wdata,
    output logic               tx_req,
    output logic               tx_probe,
    input  logic               tx_ack,
    input  logic               tx_done,
    input  logic               tx_alf,
    output logic               sched_busy,
    output logic               run_finish,
    output logic [TOTAL_W-1:0] sent_pkt_cnt,
    output logic [31:0]        sent_probe_cnt
);

    typedef enum logic [2:0] {S_IDLE, S_REQ, S_XMIT, S_GAP, S_FIN} state_t;

    state_t               state, state_nxt;
    logic [GAP_W-1:0]     gap_cycles;
    logic [PROBE_W-1:0]   probe_every;
    logic [TOTAL_W-1:0]   pkt_total;
    logic [GAP_W-1:0]     gap_cnt;
    logic [PROBE_W-1:0]   since_probe;
    logic                 stop_pend;

    logic                 cfg_ctrl, cfg_start, cfg_stop;
    logic                 is_probe, req_nxt;
    logic [TOTAL_W-1:0]   pkt_cnt_inc;

    assign cfg_ctrl    = cfg_wr && (cfg_addr == 2'd3);
    assign cfg_stop    = cfg_ctrl && cfg_wdata[1];
    assign cfg_start   = cfg_ctrl && cfg_wdata[0] && !cfg_wdata[1];
    assign is_probe    = (probe_every != '0) && (since_probe == probe_every);
    assign pkt_cnt_inc = sent_pkt_cnt + TOTAL_W'(1);

    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE: if (cfg_start) state_nxt = S_REQ;
            S_REQ: begin
                if (tx_req && tx_ack)  state_nxt = S_XMIT;
                else if (cfg_stop)     state_nxt = S_IDLE;
            end
            S_XMIT: begin
                if (tx_done) begin
                    if ((pkt_total != '0) && (pkt_cnt_inc == pkt_total)) state_nxt = S_FIN;
                    else if (stop_pend || cfg_stop)                      state_nxt = S_FIN;
                    else if (gap_cycles <= GAP_W'(1))                    state_nxt = S_REQ;
                    else                                                 state_nxt = S_GAP;
                end
            end
            // REQ is entered exactly gap_cycles cycles after the tx_done cycle
            S_GAP: begin
                if (cfg_stop)                                state_nxt = S_IDLE;
                else if (gap_cnt == gap_cycles - GAP_W'(1))  state_nxt = S_REQ;
            end
            S_FIN:   state_nxt = S_IDLE;
            default: state_nxt = S_IDLE;
        endcase
    end

    assign req_nxt = (state == S_REQ) && (state_nxt == S_REQ) && !tx_alf;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state          <= S_IDLE;
            tx_req         <= 1'b0;
            tx_probe       <= 1'b0;
            sched_busy     <= 1'b0;
            run_finish     <= 1'b0;
            gap_cycles     <= '0;
            probe_every    <= '0;
            pkt_total      <= '0;
            gap_cnt        <= '0;
            since_probe    <= '0;
            stop_pend      <= 1'b0;
            sent_pkt_cnt   <= '0;
            sent_probe_cnt <= '0;
        end else begin
            state      <= state_nxt;
            tx_req     <= req_nxt;
            tx_probe   <= req_nxt && is_probe;
            sched_busy <= (state_nxt != S_IDLE);
            run_finish <= (state_nxt == S_FIN);

            if (cfg_wr && (state == S_IDLE)) begin
                case (cfg_addr)
                    2'd0:    gap_cycles  <= cfg_wdata[GAP_W-1:0];
                    2'd1:    probe_every <= cfg_wdata[PROBE_W-1:0];
                    2'd2:    pkt_total   <= cfg_wdata[TOTAL_W-1:0];
                    default: ;
                endcase
            end

            if (state == S_IDLE)
                stop_pend <= 1'b0;
            else if (cfg_stop && ((state == S_XMIT) || (state_nxt == S_XMIT)))
                stop_pend <= 1'b1;

            if ((state == S_IDLE) && cfg_start) begin
                sent_pkt_cnt   <= '0;
                sent_probe_cnt <= '0;
                since_probe    <= '0;
            end else if ((state == S_XMIT) && tx_done) begin
                sent_pkt_cnt <= pkt_cnt_inc;
                if (is_probe) begin
                    sent_probe_cnt <= sent_probe_cnt + 32'd1;
                    since_probe    <= '0;
                end else if (since_probe != probe_every) begin
                    since_probe <= since_probe + PROBE_W'(1);
                end
            end

            if (state == S_XMIT)     gap_cnt <= GAP_W'(1);
            else if (state == S_GAP) gap_cnt <= gap_cnt + GAP_W'(1);
        end
    end

endmodule

// File: tb/tb_pgm_tx_sched.sv
// Bench for pgm_tx_sched: table of run configurations, randomized runs against an
// arithmetic model of packet pacing/probe tagging, and hand sequences for stop/alf/reset.
module tb_pgm_tx_sched;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        cfg_wr;
    logic [1:0]  cfg_addr;
    logic [63:0] cfg_wdata;
    logic        tx_req, tx_probe, tx_ack, tx_done, tx_alf;
    logic        sched_busy, run_finish;
    logic [63:0] sent_pkt_cnt;
    logic [31:0] sent_probe_cnt;

    int n_tests = 0;
    int n_fail  = 0;
    int fin_cnt = 0;

    pgm_tx_sched dut (
        .clk(clk), .rst_n(rst_n),
        .cfg_wr(cfg_wr), .cfg_addr(cfg_addr), .cfg_wdata(cfg_wdata),
        .tx_req(tx_req), .tx_probe(tx_probe), .tx_ack(tx_ack), .tx_done(tx_done),
        .tx_alf(tx_alf), .sched_busy(sched_busy), .run_finish(run_finish),
        .sent_pkt_cnt(sent_pkt_cnt), .sent_probe_cnt(sent_probe_cnt)
    );

    always #5 clk = ~clk;

    always @(negedge clk) if (run_finish === 1'b1) fin_cnt++;

    typedef struct {
        int gap, probe, total, ack_dly, done_dly, exp_pkts, exp_probes;
    } vec_t;

    task automatic tick();
        @(negedge clk);
    endtask

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Reference rules: packet k (1-based) is a probe every (probe+1)th packet;
    // tx_req is first seen max(gap,1)+1 cycles after the tx_done cycle.
    function automatic bit model_probe(input int k, input int probe);
        return (probe != 0) && ((k % (probe + 1)) == 0);
    endfunction

    function automatic int model_lat(input int gap);
        return ((gap <= 1) ? 1 : gap) + 1;
    endfunction

    function automatic int model_probes(input int total, input int probe);
        return (probe == 0) ? 0 : total / (probe + 1);
    endfunction

    task automatic cfg(input logic [1:0] a, input logic [63:0] d);
        cfg_wr = 1'b1; cfg_addr = a; cfg_wdata = d;
        tick();
        cfg_wr = 1'b0; cfg_wdata = '0;
    endtask

    task automatic wait_req(input string name, input int exp_lat, input int start_cnt);
        int cnt;
        cnt = start_cnt;
        while (tx_req !== 1'b1 && cnt < 200) begin
            tick();
            cnt++;
        end
        check(name, 64'(cnt), 64'(exp_lat));
    endtask

    task automatic send_pkt(input int k, input int probe, input int ack_dly, input int done_dly,
                            input bit stop_xmit);
        bit   stable;
        logic p0;
        check("probe_flag", 64'(tx_probe), 64'(model_probe(k, probe)));
        stable = 1'b1;
        p0     = tx_probe;
        for (int i = 0; i < ack_dly; i++) begin
            tick();
            if (tx_req !== 1'b1 || tx_probe !== p0) stable = 1'b0;
        end
        check("req_hold", 64'(stable), 64'd1);
        tx_ack = 1'b1;
        tick();
        tx_ack = 1'b0;
        check("req_drop_ack", 64'(tx_req), 64'd0);
        if (stop_xmit) cfg(2'd3, 64'd2);
        for (int i = 0; i < done_dly; i++) tick();
        tx_done = 1'b1;
        tick();
        tx_done = 1'b0;
        check("pkt_cnt", sent_pkt_cnt, 64'(k));
    endtask

    task automatic do_run(input vec_t v);
        int f0;
        f0 = fin_cnt;
        cfg(2'd0, 64'(v.gap));
        cfg(2'd1, 64'(v.probe));
        cfg(2'd2, 64'(v.total));
        cfg(2'd3, 64'd1);
        check("busy_start", 64'(sched_busy), 64'd1);
        wait_req("start_lat", 2, 1);
        for (int k = 1; k <= v.total; k++) begin
            send_pkt(k, v.probe, v.ack_dly, v.done_dly, 1'b0);
            if (k < v.total) wait_req("gap_lat", model_lat(v.gap), 1);
        end
        check("run_finish_hi", 64'(run_finish), 64'd1);
        tick();
        check("run_finish_lo", 64'(run_finish), 64'd0);
        check("busy_end", 64'(sched_busy), 64'd0);
        check("final_pkts", sent_pkt_cnt, 64'(v.exp_pkts));
        check("final_probes", 64'(sent_probe_cnt), 64'(v.exp_probes));
        check("finish_pulses", 64'(fin_cnt - f0), 64'd1);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not complete, expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        vec_t vecs[5];
        vec_t rv;
        bit   any_bad;
        int   f0;

        vecs[0] = '{0, 0, 3, 2, 5, 3, 0};
        vecs[1] = '{10, 0, 2, 2, 5, 2, 0};
        vecs[2] = '{0, 2, 6, 1, 3, 6, 2};
        vecs[3] = '{3, 3, 9, 0, 0, 9, 2};
        vecs[4] = '{1, 1, 5, 3, 2, 5, 2};

        rst_n = 1'b0; cfg_wr = 1'b0; cfg_addr = '0; cfg_wdata = '0;
        tx_ack = 1'b0; tx_done = 1'b0; tx_alf = 1'b0;
        repeat (3) tick();
        rst_n = 1'b1;
        tick();
        check("reset_outputs", {tx_req, tx_probe, sched_busy, run_finish, sent_pkt_cnt,
                                sent_probe_cnt} == '0, 64'd1);

        // start+stop together: stop wins; stop in IDLE does nothing
        cfg(2'd3, 64'd3);
        check("start_stop_idle", 64'(sched_busy), 64'd0);
        cfg(2'd3, 64'd2);
        check("stop_in_idle", 64'(sched_busy), 64'd0);

        foreach (vecs[i]) do_run(vecs[i]);

        for (int r = 0; r < 6; r++) begin
            rv.gap        = int'($urandom_range(0, 6));
            rv.probe      = int'($urandom_range(0, 3));
            rv.total      = int'($urandom_range(1, 8));
            rv.ack_dly    = int'($urandom_range(0, 3));
            rv.done_dly   = int'($urandom_range(0, 4));
            rv.exp_pkts   = rv.total;
            rv.exp_probes = model_probes(rv.total, rv.probe);
            do_run(rv);
        end

        // unbounded run, busy write to gap ignored, stop during XMIT of pkt 4
        f0 = fin_cnt;
        cfg(2'd0, 64'd2); cfg(2'd1, 64'd0); cfg(2'd2, 64'd0); cfg(2'd3, 64'd1);
        wait_req("start_lat", 2, 1);
        for (int k = 1; k <= 4; k++) begin
            send_pkt(k, 0, 1, 2, k == 4);
            if (k == 1) begin
                cfg(2'd0, 64'd40);
                wait_req("gap_lat_busy_wr", model_lat(2), 2);
            end else if (k < 4) begin
                wait_req("gap_lat", model_lat(2), 1);
            end
        end
        check("stop_xmit_finish", 64'(run_finish), 64'd1);
        tick();
        check("stop_xmit_pulses", 64'(fin_cnt - f0), 64'd1);
        check("stop_xmit_busy", 64'(sched_busy), 64'd0);
        check("stop_xmit_pkts", sent_pkt_cnt, 64'd4);

        // stop during GAP
        f0 = fin_cnt;
        cfg(2'd0, 64'd10); cfg(2'd2, 64'd0); cfg(2'd3, 64'd1);
        wait_req("start_lat", 2, 1);
        send_pkt(1, 0, 0, 0, 1'b0);
        tick(); tick();
        cfg(2'd3, 64'd2);
        check("stop_gap_busy", 64'(sched_busy), 64'd0);
        any_bad = 1'b0;
        for (int i = 0; i < 15; i++) begin
            tick();
            if (tx_req !== 1'b0 || sched_busy !== 1'b0) any_bad = 1'b1;
        end
        check("stop_gap_quiet", 64'(any_bad), 64'd0);
        check("stop_gap_no_finish", 64'(fin_cnt - f0), 64'd0);
        check("stop_gap_pkts", sent_pkt_cnt, 64'd1);

        // almost-full hold, ack without req ignored, stop+ack same cycle
        cfg(2'd0, 64'd0); cfg(2'd1, 64'd0); cfg(2'd2, 64'd2);
        tx_alf = 1'b1;
        cfg(2'd3, 64'd1);
        any_bad = 1'b0;
        for (int i = 0; i < 20; i++) begin
            tx_ack = (i == 5);
            tick();
            if (tx_req !== 1'b0) any_bad = 1'b1;
        end
        tx_ack = 1'b0;
        check("alf_req_low", 64'(any_bad), 64'd0);
        check("alf_busy", 64'(sched_busy), 64'd1);
        tx_alf = 1'b0;
        tick();
        check("req_after_alf", 64'(tx_req), 64'd1);
        tx_alf = 1'b1;
        tick();
        check("req_drop_alf", 64'(tx_req), 64'd0);
        tx_alf = 1'b0;
        tick();
        check("req_resume_alf", 64'(tx_req), 64'd1);
        tx_ack = 1'b1; cfg_wr = 1'b1; cfg_addr = 2'd3; cfg_wdata = 64'd2;
        tick();
        tx_ack = 1'b0; cfg_wr = 1'b0; cfg_wdata = '0;
        check("ack_wins_req", 64'(tx_req), 64'd0);
        check("ack_wins_busy", 64'(sched_busy), 64'd1);
        tick();
        tx_done = 1'b1;
        tick();
        tx_done = 1'b0;
        check("ack_wins_finish", 64'(run_finish), 64'd1);
        check("ack_wins_pkts", sent_pkt_cnt, 64'd1);
        tick();
        check("ack_wins_idle", 64'(sched_busy), 64'd0);

        // async reset mid-XMIT clears outputs and config
        cfg(2'd0, 64'd5); cfg(2'd2, 64'd0); cfg(2'd3, 64'd1);
        wait_req("start_lat", 2, 1);
        send_pkt(1, 0, 0, 0, 1'b0);
        wait_req("gap_lat", model_lat(5), 1);
        tx_ack = 1'b1;
        tick();
        tx_ack = 1'b0;
        check("xmit_busy", 64'(sched_busy), 64'd1);
        rst_n = 1'b0;
        #1;
        check("async_rst_outputs", {tx_req, tx_probe, sched_busy, run_finish, sent_pkt_cnt,
                                    sent_probe_cnt} == '0, 64'd1);
        tick();
        rst_n = 1'b1;
        tick();
        cfg(2'd3, 64'd1);
        wait_req("start_lat_rst", 2, 1);
        send_pkt(1, 0, 0, 0, 1'b0);
        wait_req("gap_after_rst", model_lat(0), 1);
        cfg(2'd3, 64'd2);
        check("stop_req_idle", 64'(sched_busy), 64'd0);
        tick();
        check("stop_req_low", 64'(tx_req), 64'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
